// File: rtl/seq_divider_8.sv
// Sequential signed restoring divider: 8-bit two's-complement operands, one quotient bit per clock.
// Quotient truncates toward zero and the remainder takes the sign of the dividend.
module seq_divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on start
  // LOAD  | record signs, form magnitudes, clear partial remainder
  // ITER  | WIDTH restoring shift/subtract steps
  // FIXUP | restore signs, detect most-negative / -1
  // DONE  | results valid, done pulses for one cycle
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic             r_sign_n;
  logic             r_sign_d;
  logic [WIDTH-1:0] r_mag_d;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;
  logic             r_ov;

  logic [WIDTH-1:0] w_mag_n;
  logic [WIDTH-1:0] w_mag_d;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_q_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_trial_ok;
  logic             w_last_iter;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_ovf_case;
  logic             w_div_by_zero;

  // Magnitude of the most-negative value wraps to itself, which reads correctly as unsigned.
  assign w_mag_n = r_dividend[WIDTH-1] ? -r_dividend : r_dividend;
  assign w_mag_d = r_divisor[WIDTH-1]  ? -r_divisor  : r_divisor;

  assign w_rem_sh    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_q_sh      = {r_q[WIDTH-2:0], 1'b0};
  assign w_trial     = w_rem_sh - {1'b0, r_mag_d};
  assign w_trial_ok  = ~w_trial[WIDTH];
  assign w_last_iter = (r_count == LAST_CNT);

  assign w_quot_fix    = (r_sign_n ^ r_sign_d) ? -r_q : r_q;
  assign w_rem_fix     = r_sign_n ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  assign w_ovf_case    = (r_dividend == MOST_NEG) && (r_divisor == '1);
  assign w_div_by_zero = (r_divisor == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_sign_n   <= 1'b0;
      r_sign_d   <= 1'b0;
      r_mag_d    <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_count    <= '0;
      r_quot     <= '0;
      r_remo     <= '0;
      r_dz       <= 1'b0;
      r_ov       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= dividend_i;
            r_divisor  <= divisor_i;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sign_n <= r_dividend[WIDTH-1];
          r_sign_d <= r_divisor[WIDTH-1];
          r_mag_d  <= w_mag_d;
          r_rem    <= '0;
          r_q      <= w_mag_n;
          r_count  <= '0;
          if (w_div_by_zero) begin
            r_quot  <= '1;
            r_remo  <= r_dividend;
            r_dz    <= 1'b1;
            r_ov    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (w_trial_ok) begin
            r_rem <= w_trial;
            r_q   <= w_q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            r_rem <= w_rem_sh;
            r_q   <= w_q_sh;
          end
          r_count <= r_count + 1'b1;
          if (w_last_iter) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_dz <= 1'b0;
          r_ov <= w_ovf_case;
          if (w_ovf_case) begin
            r_quot <= MOST_NEG;
            r_remo <= '0;
          end else begin
            r_quot <= w_quot_fix;
            r_remo <= w_rem_fix;
          end
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign div_zero  = r_dz;
  assign overflow  = r_ov;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_divider_8.sv
// Scoreboard bench for seq_divider_8: directed operand pairs with hand-computed results,
// per-edge done/busy timing checks, ignored start pulses and an asynchronous mid-run reset.
module tb_seq_divider_8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend_i = '0;
  logic [7:0] divisor_i = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;
  logic       overflow;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  seq_divider_8 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient",  quotient,  e.q);
        check("remainder", remainder, e.r);
        check("div_zero",  div_zero,  e.dz);
        check("overflow",  overflow,  e.ov);
      end
    end
  end

  // Issue one operation; done must rise exactly after edge lat and busy must fall one edge later.
  task automatic do_op(input logic [7:0] dvd, input logic [7:0] dvs,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input logic eov, input int lat,
                       input bit busy_pulses);
    exp_t e;
    @(negedge clk);
    dividend_i = dvd;
    divisor_i  = dvs;
    start      = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start      = 1'b0;
    dividend_i = ~dvd;
    divisor_i  = dvs + 8'd3;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      check("done_timing", done, (k == lat) ? 32'd1 : 32'd0);
      if (busy_pulses && k == 2) begin
        start = 1'b1; dividend_i = 8'h10; divisor_i = 8'h03;
      end
      if (busy_pulses && k == 3) start = 1'b0;
      if (busy_pulses && k == lat) begin
        start = 1'b1; dividend_i = 8'h20; divisor_i = 8'h04;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_fall", busy, 32'd0);
    check("done_fall", done, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    check("rst_quotient",  quotient,  32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_busy",      busy,      32'd0);
    check("rst_done",      done,      32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 10, 1'b0);
    do_op(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 10, 1'b0);
    do_op(8'h07, 8'h64, 8'h00, 8'h07, 1'b0, 1'b0, 10, 1'b0);
    do_op(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 10, 1'b0);
    do_op(8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 1,  1'b0);
    do_op(8'h06, 8'h03, 8'h02, 8'h00, 1'b0, 1'b0, 10, 1'b0);
    do_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 10, 1'b0);
    do_op(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 10, 1'b0);
    do_op(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 10, 1'b1);

    // Start 100/7 and abort it with an asynchronous reset after E5.
    @(negedge clk);
    dividend_i = 8'h64;
    divisor_i  = 8'h07;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_quotient",  quotient,  32'd0);
    check("async_remainder", remainder, 32'd0);
    check("async_busy",      busy,      32'd0);
    check("async_done",      done,      32'd0);
    check("async_div_zero",  div_zero,  32'd0);
    check("async_overflow",  overflow,  32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(8'h32, 8'h05, 8'h0A, 8'h00, 1'b0, 1'b0, 10, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
